spart_tx_fifo: RTL and testbench



---
 rtl/spart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_spart_tx_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx_fifo.sv
`timescale 1ns/1ps
// SPART transmitter with an N-entry transmit FIFO; frames are paced by the baud enable
// and go out back-to-back while data is queued.
module spart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          iocs,
    input  logic                          iorw,
    input  logic [1:0]                    ioaddr,
    input  logic [7:0]                    data,
    output logic                          txd,
    output logic                          tbr,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   par_bit;

    logic push_req;
    logic clr_req;
    logic fifo_empty;
    logic fifo_full;
    logic last_stop;
    logic pop;
    logic push_ok;
    logic overflow;
    logic par_calc;

    always_comb begin
        push_req   = iocs & ~iorw & (ioaddr == 2'b00);
        clr_req    = iocs & ~iorw & (ioaddr == 2'b01);
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
        last_stop  = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
        pop        = enable && !fifo_empty && ((state == IDLE) || last_stop);
        // A full FIFO still accepts a push on the edge that pops its head.
        push_ok    = push_req && (!fifo_full || pop);
        overflow   = push_req && !push_ok;
        par_calc   = (^mem[rd_ptr]) ^ (PARITY_MODE == 2);
        tbr        = !fifo_full;
        tx_busy    = (state != IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= data[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (overflow) begin
                ovf <= 1'b1;
            end else if (clr_req) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            txd       <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        par_bit   <= par_calc;
                        state     <= START;
                        txd       <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    txd     <= shift_reg[0];
                end
                DATA: begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        stop_cnt <= 1'b0;
                        if (PARITY_MODE != 0) begin
                            state <= PARITY;
                            txd   <= par_bit;
                        end else begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end
                    end else begin
                        // txd takes the next bit directly so it lines up with the shift.
                        shift_reg <= shift_reg >> 1;
                        txd       <= shift_reg[1];
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    state    <= STOP;
                    stop_cnt <= 1'b0;
                    txd      <= 1'b1;
                end
                STOP: begin
                    if (last_stop) begin
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            par_bit   <= par_calc;
                            state     <= START;
                            txd       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            txd   <= 1'b1;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                        txd      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_tx_fifo.sv
`timescale 1ns/1ps
// Bench for spart_tx_fifo: four parameter variants share one bus; a per-variant
// frame scoreboard is filled on each accepted push and drained by a line monitor.
module tb_spart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] data;
    logic [3:0] txd_w;
    logic [3:0] tbr_w;
    logic [3:0] busy_w;
    logic [3:0] ovf_w;
    logic [2:0] cnt_w [4];

    int n_total = 0;
    int n_bad   = 0;
    int en_period = 0;

    int cfg_db  [4] = '{8, 8, 8, 7};
    int cfg_pm  [4] = '{0, 1, 2, 0};
    int cfg_len [4] = '{10, 11, 11, 10};

    logic [11:0] exp_q [4][$];
    bit          in_fr    [4] = '{0, 0, 0, 0};
    bit          gap_pend [4] = '{0, 0, 0, 0};
    int          bpos     [4] = '{0, 0, 0, 0};
    logic [11:0] cap      [4];

    spart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .enable(enable), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .data(data), .txd(txd_w[0]), .tbr(tbr_w[0]), .tx_busy(busy_w[0]),
        .fifo_count(cnt_w[0]), .ovf(ovf_w[0]));
    spart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .enable(enable), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .data(data), .txd(txd_w[1]), .tbr(tbr_w[1]), .tx_busy(busy_w[1]),
        .fifo_count(cnt_w[1]), .ovf(ovf_w[1]));
    spart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .enable(enable), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .data(data), .txd(txd_w[2]), .tbr(tbr_w[2]), .tx_busy(busy_w[2]),
        .fifo_count(cnt_w[2]), .ovf(ovf_w[2]));
    spart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .enable(enable), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .data(data), .txd(txd_w[3]), .tbr(tbr_w[3]), .tx_busy(busy_w[3]),
        .fifo_count(cnt_w[3]), .ovf(ovf_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick source; en_period==0 parks it low so steps can pulse enable by hand.
    initial begin
        int en_cnt;
        en_cnt = 0;
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (en_period == 0) begin
                enable = 1'b0;
            end else if (en_cnt >= en_period - 1) begin
                enable = 1'b1;
                en_cnt = 0;
            end else begin
                enable = 1'b0;
                en_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bits in transmit order; unused high positions stay 1 like the idle line.
    function automatic logic [11:0] mk_frame(input logic [7:0] b, input int db, input int pm);
        logic [11:0] f;
        logic        par;
        int          p;
        f    = '1;
        f[0] = 1'b0;
        par  = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[1 + i] = b[i];
            par      = par ^ b[i];
        end
        p = 1 + db;
        if (pm != 0) f[p] = (pm == 1) ? par : ~par;
        return f;
    endfunction

    // Line monitor: one sample per bit time, taken while the tick is high.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                in_fr[k]    = 1'b0;
                gap_pend[k] = 1'b0;
            end else if (enable) begin
                if (!in_fr[k]) begin
                    if (gap_pend[k]) begin
                        n_total++;
                        assert (txd_w[k] === 1'b0) else begin
                            n_bad++;
                            $error("FAIL gap[%0d]: txd=%b required start bit 0", k, txd_w[k]);
                        end
                        gap_pend[k] = 1'b0;
                    end
                    if (txd_w[k] === 1'b0) begin
                        in_fr[k] = 1'b1;
                        cap[k]   = '1;
                        cap[k][0] = 1'b0;
                        bpos[k]  = 1;
                    end
                end else begin
                    cap[k][bpos[k]] = txd_w[k];
                    bpos[k]++;
                    if (bpos[k] == cfg_len[k]) begin
                        in_fr[k] = 1'b0;
                        n_total++;
                        assert (exp_q[k].size() != 0) else begin
                            n_bad++;
                            $error("FAIL unexpected_frame[%0d]: got %h, none queued", k, cap[k]);
                        end
                        if (exp_q[k].size() != 0) begin
                            logic [11:0] ev;
                            ev = exp_q[k].pop_front();
                            n_total++;
                            assert (cap[k] === ev) else begin
                                n_bad++;
                                $error("FAIL frame[%0d]: observed=%h expected=%h", k, cap[k], ev);
                            end
                            gap_pend[k] = (exp_q[k].size() != 0);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit accept);
        @(posedge clk);
        #2;
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = a;
        data   = d;
        if (a == 2'b00 && accept) begin
            for (int k = 0; k < 4; k++) exp_q[k].push_back(mk_frame(d, cfg_db[k], cfg_pm[k]));
        end
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #2;
        iocs = 1'b0;
        iorw = 1'b0;
    endtask

    function automatic bit busy_any();
        bit b;
        b = 1'b0;
        for (int k = 0; k < 4; k++) if (exp_q[k].size() != 0 || in_fr[k]) b = 1'b1;
        return b;
    endfunction

    task automatic wait_drain(input string tag, input int maxc);
        int c;
        c = 0;
        while (c < maxc && busy_any()) begin
            @(posedge clk);
            c++;
        end
        n_total++;
        assert (c < maxc) else begin
            n_bad++;
            $error("FAIL %s: frames still pending after %0d cycles, required drained", tag, c);
        end
    endtask

    initial begin
        int c;
        int zeros;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", {7'd0, txd_w[0]}, 8'd1);
        chk("rst_tbr", {7'd0, tbr_w[0]}, 8'd1);
        chk("rst_busy", {7'd0, busy_w[0]}, 8'd0);
        chk("rst_cnt", {5'd0, cnt_w[0]}, 8'd0);
        chk("rst_ovf", {7'd0, ovf_w[0]}, 8'd0);
        #1 rst = 1'b0;

        // Single 0x2C at a slow baud: latency, all formats, busy after stop.
        en_period = 326;
        wr(2'b00, 8'h2C, 1'b1);
        idle_bus();
        chk("t1_cnt", {5'd0, cnt_w[0]}, 8'd1);
        chk("t1_busy", {7'd0, busy_w[0]}, 8'd1);
        c = 0;
        while (c < 400 && enable !== 1'b1) begin @(posedge clk); #2; c++; end
        chk("t1_pre_start_txd", {7'd0, txd_w[0]}, 8'd1);
        @(posedge clk);
        #1;
        chk("t1_start_txd", {7'd0, txd_w[0]}, 8'd0);
        chk("t1_popped_cnt", {5'd0, cnt_w[0]}, 8'd0);
        wait_drain("t1_drain", 5000);
        repeat (330) @(posedge clk);
        #1;
        chk("t1_busy_after", {7'd0, busy_w[0]}, 8'd0);
        chk("t1_idle_txd", {4'd0, txd_w}, 8'h0F);

        // A read cycle changes nothing, then 0x9F with odd/even parity.
        en_period = 3;
        @(posedge clk); #2;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; data = 8'hAA;
        idle_bus();
        chk("t2_read_noop", {5'd0, cnt_w[0]}, 8'd0);
        wr(2'b00, 8'h9F, 1'b1);
        idle_bus();
        wait_drain("t2_drain", 2000);

        // Enable held high; 0xFF then 0x00 back-to-back exposes any extra bit in 7N2.
        en_period = 1;
        wr(2'b00, 8'hFF, 1'b1);
        wr(2'b00, 8'h00, 1'b1);
        idle_bus();
        wait_drain("t3_drain", 500);

        // Overflow: five pushes with no ticks; fifth dropped.
        en_period = 0;
        repeat (30) @(posedge clk);
        wr(2'b00, 8'h11, 1'b1);
        wr(2'b00, 8'h22, 1'b1);
        wr(2'b00, 8'h33, 1'b1);
        wr(2'b00, 8'h44, 1'b1);
        wr(2'b00, 8'h55, 1'b0);
        chk("t4_cnt_full", {5'd0, cnt_w[0]}, 8'd4);
        chk("t4_tbr_full", {7'd0, tbr_w[0]}, 8'd0);
        chk("t4_ovf_before", {7'd0, ovf_w[0]}, 8'd0);
        idle_bus();
        chk("t4_ovf_set", {4'd0, ovf_w}, 8'h0F);
        chk("t4_cnt_after_drop", {5'd0, cnt_w[0]}, 8'd4);
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_cnt_pop", {5'd0, cnt_w[0]}, 8'd3);
        chk("t4_tbr_pop", {7'd0, tbr_w[0]}, 8'd1);
        en_period = 4;
        wait_drain("t4_drain", 1000);
        chk("t4_cnt_empty", {5'd0, cnt_w[0]}, 8'd0);
        chk("t4_ovf_sticky", {7'd0, ovf_w[0]}, 8'd1);
        wr(2'b01, 8'h00, 1'b0);
        idle_bus();
        chk("t4_ovf_clr", {7'd0, ovf_w[0]}, 8'd0);

        // Full FIFO: push and pop on the same edge.
        en_period = 0;
        repeat (60) @(posedge clk);
        wr(2'b00, 8'hA1, 1'b1);
        wr(2'b00, 8'hA2, 1'b1);
        wr(2'b00, 8'hA3, 1'b1);
        wr(2'b00, 8'hA4, 1'b1);
        idle_bus();
        chk("t5_cnt_full", {5'd0, cnt_w[0]}, 8'd4);
        @(posedge clk); #2;
        enable = 1'b1;
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; data = 8'hA5;
        for (int k = 0; k < 4; k++) exp_q[k].push_back(mk_frame(8'hA5, cfg_db[k], cfg_pm[k]));
        @(posedge clk);
        #1;
        chk("t5_cnt_same", {5'd0, cnt_w[0]}, 8'd4);
        chk("t5_ovf", {4'd0, ovf_w}, 8'h00);
        chk("t5_tbr", {7'd0, tbr_w[0]}, 8'd0);
        #1 iocs = 1'b0;
        en_period = 5;
        wait_drain("t5_drain", 2000);

        // Reset in the middle of DATA with bytes still queued.
        en_period = 0;
        repeat (20) @(posedge clk);
        wr(2'b00, 8'h5A, 1'b1);
        wr(2'b00, 8'h3C, 1'b1);
        wr(2'b00, 8'h0F, 1'b1);
        idle_bus();
        en_period = 4;
        c = 0;
        while (c < 500 && !(in_fr[0] && bpos[0] >= 4)) begin @(posedge clk); c++; end
        chk("t6_reached_data", {7'd0, in_fr[0]}, 8'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(posedge clk);
        #1;
        chk("t6_txd", {4'd0, txd_w}, 8'h0F);
        chk("t6_cnt", {5'd0, cnt_w[0]}, 8'd0);
        chk("t6_tbr", {7'd0, tbr_w[0]}, 8'd1);
        chk("t6_busy", {7'd0, busy_w[0]}, 8'd0);
        #1 rst = 1'b0;
        zeros = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (txd_w !== 4'hF) zeros++;
        end
        chk("t6_no_frames", zeros[7:0], 8'd0);
        chk("t6_cnt_end", {5'd0, cnt_w[0]}, 8'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
